// File: rtl/instruction_loader.sv
// instruction_loader: packs a UART byte stream (big-endian, 4 bytes per word)
// into 32-bit instructions and writes them to instruction memory at
// consecutive word addresses starting at 0. Loading stops on the HALT word
// or when the last memory word has been written.
// Optional feature: define LOADER_TIMEOUT_EN to discard a partial word after
// TIMEOUT_CYCLES idle cycles between bytes (pulsing o_timeout_err).
module instruction_loader #(
    parameter int NB_PC          = 32,
    parameter int N_WORDS        = 256,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load_start,
    input  logic [7:0]       i_rx_data,
    input  logic             i_rx_valid,
    output logic             o_rf_instruction_write_enb,
    output logic [NB_PC-1:0] o_rf_instruction_addr,
    output logic [NB_PC-1:0] o_rf_instruction_data,
    output logic             o_busy,
    output logic             o_load_done,
    output logic             o_overflow,
    output logic [NB_PC-1:0] o_word_count,
    output logic             o_timeout_err
);

    localparam logic [NB_PC-1:0] LAST_ADDR = NB_PC'(N_WORDS - 1);
    localparam logic [NB_PC-1:0] HALT_WORD = NB_PC'(32'hFFFFFFFF);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RECV,
        ST_WRITE,
        ST_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [NB_PC-1:0] addr_q, addr_d;
    logic [NB_PC-1:0] wr_addr_q, wr_addr_d;
    logic [NB_PC-1:0] wr_data_q, wr_data_d;
    logic [31:0]      word_q, word_d;
    logic [1:0]       byte_cnt_q, byte_cnt_d;
    logic [NB_PC-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;

`ifdef LOADER_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             tmo_err_q, tmo_err_d;
`endif

    // Next-state logic: restart has priority over byte reception in every state;
    // the write address/data outputs only change when a new word is latched.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        word_d     = word_q;
        byte_cnt_d = byte_cnt_q;
        count_d    = count_q;
        overflow_d = overflow_q;
`ifdef LOADER_TIMEOUT_EN
        tmo_d      = '0;
        tmo_err_d  = 1'b0;
`endif

        if (i_load_start) begin
            state_d    = ST_RECV;
            addr_d     = '0;
            word_d     = '0;
            byte_cnt_d = '0;
            count_d    = '0;
            overflow_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                end
                ST_RECV: begin
                    if (i_rx_valid) begin
                        word_d = {word_q[23:0], i_rx_data};
                        if (byte_cnt_q == 2'd3) begin
                            byte_cnt_d = '0;
                            wr_addr_d  = addr_q;
                            wr_data_d  = NB_PC'({word_q[23:0], i_rx_data});
                            state_d    = ST_WRITE;
                        end else begin
                            byte_cnt_d = byte_cnt_q + 2'd1;
                        end
                    end
`ifdef LOADER_TIMEOUT_EN
                    else if (byte_cnt_q != 2'd0) begin
                        if (tmo_q == TMO_LAST) begin
                            byte_cnt_d = '0;
                            word_d     = '0;
                            tmo_err_d  = 1'b1;
                        end else begin
                            tmo_d = tmo_q + TMO_W'(1);
                        end
                    end
`endif
                end
                ST_WRITE: begin
                    count_d = count_q + NB_PC'(1);
                    if (wr_data_q == HALT_WORD) begin
                        state_d = ST_DONE;
                    end else if (addr_q == LAST_ADDR) begin
                        state_d    = ST_DONE;
                        overflow_d = 1'b1;
                    end else begin
                        addr_d  = addr_q + NB_PC'(1);
                        state_d = ST_RECV;
                        if (i_rx_valid) begin
                            word_d     = {word_q[23:0], i_rx_data};
                            byte_cnt_d = 2'd1;
                        end
                    end
                end
                ST_DONE: begin
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State register with synchronous reset clearing everything visible.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            word_q     <= '0;
            byte_cnt_q <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            word_q     <= word_d;
            byte_cnt_q <= byte_cnt_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

`ifdef LOADER_TIMEOUT_EN
    // Inter-byte timeout counter and its one-cycle error pulse.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            tmo_q     <= '0;
            tmo_err_q <= 1'b0;
        end else begin
            tmo_q     <= tmo_d;
            tmo_err_q <= tmo_err_d;
        end
    end

    assign o_timeout_err = tmo_err_q;
`else
    assign o_timeout_err = 1'b0;
`endif

    assign o_rf_instruction_write_enb = (state_q == ST_WRITE);
    assign o_rf_instruction_addr      = wr_addr_q;
    assign o_rf_instruction_data      = wr_data_q;
    assign o_busy                     = (state_q == ST_RECV) || (state_q == ST_WRITE);
    assign o_load_done                = (state_q == ST_DONE);
    assign o_overflow                 = overflow_q;
    assign o_word_count               = count_q;

endmodule

// File: doc/instruction_loader.md
# instruction_loader

Upstream loader for the instruction fetch stage. It receives a program as a byte stream from the UART receiver and packs every four bytes into a 32-bit instruction word. Each word is written into instruction memory through the fetch stage's `i_rf_instruction_*` write port, at consecutive word addresses starting at 0. Loading ends on the HALT word (`32'hFFFFFFFF`) or when memory is full; `o_load_done` then tells the debug unit it may enable the pipeline.

## Interface
Parameters:
- `NB_PC`, 32, width of write address, write data and word count.
- `N_WORDS`, 256, instruction memory depth in words; last valid address is `N_WORDS-1`.
- `TIMEOUT_CYCLES`, 100000, inter-byte timeout; used only with `LOADER_TIMEOUT_EN`.

Ports:
- `i_clk`, in, 1, clock.
- `i_rst`, in, 1, reset; synchronous, active-high.
- `i_load_start`, in, 1, one-cycle strobe that starts (or restarts) a load at address 0.
- `i_rx_data`, in, 8, received byte.
- `i_rx_valid`, in, 1, one-cycle strobe; `i_rx_data` is valid in that cycle.
- `o_rf_instruction_write_enb`, out, 1, memory write strobe, one cycle per word.
- `o_rf_instruction_addr`, out, NB_PC, word address (increments by 1 per word).
- `o_rf_instruction_data`, out, NB_PC, assembled instruction.
- `o_busy`, out, 1, high in RECV and WRITE.
- `o_load_done`, out, 1, level; high in DONE.
- `o_overflow`, out, 1, level; set when DONE is reached at `N_WORDS-1` without a HALT word.
- `o_word_count`, out, NB_PC, number of words written in the current load.
- `o_timeout_err`, out, 1, one-cycle pulse when a partial word is discarded on timeout.

## Operation
- FSM states: IDLE, RECV, WRITE, DONE.
- Reset value of every output is 0; the FSM resets to IDLE.
- Priority in every cycle: `i_rst` > `i_load_start` > `i_rx_valid`.
- IDLE
  - `i_rx_valid` is ignored.
  - `i_load_start` moves to RECV and clears address, byte count, `o_word_count`, `o_overflow` and `o_load_done`.
- RECV
  - Each `i_rx_valid` shifts the byte in: word <= {word[23:0], byte}. The first byte ends up as bits [31:24] (big-endian).
  - The byte counter runs 0..3. The 4th byte moves to WRITE.
- WRITE (exactly one cycle)
  - `o_rf_instruction_write_enb` = 1, with the current address and assembled word on the outputs. `o_word_count` increments.
  - Word == `32'hFFFFFFFF`: go to DONE. The HALT word itself is written.
  - Otherwise, address == `N_WORDS-1`: go to DONE and set `o_overflow`.
  - Otherwise: address increments and the FSM returns to RECV.
  - An `i_rx_valid` byte arriving in the WRITE cycle is captured as byte 0 of the next word; no byte is ever dropped.
- DONE
  - `o_load_done` = 1; all further bytes are ignored.
  - `i_load_start` reloads as described for IDLE.
- `i_load_start` in RECV or WRITE aborts the current load and restarts at address 0. The partial word is discarded. If the restart lands in the WRITE cycle, the write pulse for that cycle still happens.
- Reset mid-load returns to IDLE with all outputs 0. Words already in memory are not cleared.
- Address and word-count arithmetic is unsigned, NB_PC bits wide. The address never exceeds `N_WORDS-1`.

## Timing
- Write latency: the write strobe is registered and appears the cycle after the 4th byte's `i_rx_valid`. It lasts exactly one cycle.
- `o_load_done` and `o_overflow` rise the cycle after the final write strobe.
- `o_busy` is high from the cycle after `i_load_start` until `o_load_done` rises.
- Back-to-back `i_rx_valid` every cycle is supported at full rate: 4 bytes give one write, with no stall.
- `o_rf_instruction_addr` and `o_rf_instruction_data` are held stable outside the write strobe.

## Configuration
- `LOADER_TIMEOUT_EN` defined:
  - A counter of width `$clog2(TIMEOUT_CYCLES+1)` runs in RECV while byte count ≠ 0. It clears on every `i_rx_valid`.
  - On reaching `TIMEOUT_CYCLES`, the partial word is discarded, byte count returns to 0, `o_timeout_err` pulses for one cycle, and the FSM stays in RECV with the address unchanged.
- `LOADER_TIMEOUT_EN` undefined:
  - No counter is built and `o_timeout_err` is tied to 0.
  - A partial word waits indefinitely for its remaining bytes.

## Test plan
- Reset, start, then bytes 20 01 00 05 and FF FF FF FF:
  - Writes `32'h20010005` to address 0, then `32'hFFFFFFFF` to address 1.
  - `o_word_count` = 2 and `o_load_done` = 1 the next cycle.
- Bytes on 12 consecutive cycles with no HALT word (N_WORDS = 256): three writes to addresses 0..2, each exactly one cycle, with no lost byte.
- N_WORDS = 4, 16 non-HALT bytes: 4 writes, DONE with `o_overflow` = 1 and `o_word_count` = 4.
- Two bytes, then `i_load_start`, then AA BB CC DD: a single write of `32'hAABBCCDD` to address 0.
- With `LOADER_TIMEOUT_EN` and TIMEOUT_CYCLES = 10:
  - Byte 11, then 10 idle cycles: `o_timeout_err` pulses and nothing is written.
  - Then 01 02 03 04: writes `32'h01020304` to address 0.
- Assert `i_rst` the cycle after the 3rd write strobe: all outputs 0 and the FSM in IDLE. Bytes sent afterwards cause no write until `i_load_start`.
